// File: rtl/weight_frame_loader.sv
// rtl/weight_frame_loader.sv - framed, length/checksum-validated weight loader into a packed block RAM
// Frame: AA 55 LEN_LO LEN_HI payload[LEN] CSUM 55 AA; payload is packed little-endian into words.
module weight_frame_loader #(
  parameter int WORD_BYTES  = 1,
  parameter int DEPTH_WORDS = 16384,
  parameter int ADDR_W      = 14
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              in_data,
  input  logic                    in_valid,
  input  logic [ADDR_W-1:0]       rd_addr,
  output logic [8*WORD_BYTES-1:0] rd_data,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [1:0]              err_code,
  output logic [15:0]             byte_count
);

  localparam int          W       = 8 * WORD_BYTES;
  localparam int          LANE_W  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [16:0] MAX_LEN = 17'(WORD_BYTES * DEPTH_WORDS);

  typedef enum logic [3:0] {
    S_IDLE, S_SYNC, S_LEN_LO, S_LEN_HI, S_PAYLOAD,
    S_CSUM, S_END1, S_END2, S_DONE, S_ERROR
  } state_t;

  state_t            state;
  logic [7:0]        len_lo;
  logic [15:0]       len;
  logic [7:0]        csum;
  logic [LANE_W-1:0] lane;
  logic [ADDR_W-1:0] waddr;
  logic [W-1:0]      pack;
  logic [W-1:0]      mem [DEPTH_WORDS];

  logic [W-1:0]      merged;
  logic [15:0]       len_rx;
  logic              last_byte;
  logic              word_full;
  logic              we;

  // pack is cleared after every write, so unfilled lanes of a partial word read as zero
  always_comb begin
    merged = pack;
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (lane == LANE_W'(i)) merged[8*i +: 8] = in_data;
    end
    len_rx    = {in_data, len_lo};
    last_byte = (byte_count == len - 16'd1);
    word_full = (lane == LANE_W'(WORD_BYTES - 1));
    we        = in_valid && (state == S_PAYLOAD) && (last_byte || word_full);
  end

  // No reset on the array: contents survive rst; read-first on same-word collisions
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= merged;
    rd_data <= mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      err_code   <= 2'd0;
      byte_count <= 16'd0;
      csum       <= 8'd0;
      lane       <= '0;
      waddr      <= '0;
      pack       <= '0;
      len_lo     <= 8'd0;
      len        <= 16'd0;
    end else if (in_valid) begin
      unique case (state)
        S_IDLE: begin
          if (in_data == 8'hAA) state <= S_SYNC;
        end
        S_SYNC: begin
          if (in_data == 8'h55) begin
            state      <= S_LEN_LO;
            busy       <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
            err_code   <= 2'd0;
            byte_count <= 16'd0;
            csum       <= 8'd0;
            lane       <= '0;
            waddr      <= '0;
            pack       <= '0;
          end else if (in_data != 8'hAA) begin
            state <= S_IDLE;
          end
        end
        S_LEN_LO: begin
          len_lo <= in_data;
          state  <= S_LEN_HI;
        end
        S_LEN_HI: begin
          len <= len_rx;
          if (len_rx == 16'd0 || {1'b0, len_rx} > MAX_LEN) begin
            state    <= S_ERROR;
            busy     <= 1'b0;
            error    <= 1'b1;
            err_code <= 2'd1;
          end else begin
            state <= S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          csum       <= csum + in_data;
          byte_count <= byte_count + 16'd1;
          if (we) begin
            pack  <= '0;
            lane  <= '0;
            waddr <= waddr + ADDR_W'(1);
          end else begin
            pack <= merged;
            lane <= lane + LANE_W'(1);
          end
          if (last_byte) state <= S_CSUM;
        end
        S_CSUM: begin
          if (in_data == csum) begin
            state <= S_END1;
          end else begin
            state    <= S_ERROR;
            busy     <= 1'b0;
            error    <= 1'b1;
            err_code <= 2'd2;
          end
        end
        S_END1: begin
          if (in_data == 8'h55) begin
            state <= S_END2;
          end else begin
            state    <= S_ERROR;
            busy     <= 1'b0;
            error    <= 1'b1;
            err_code <= 2'd3;
          end
        end
        S_END2: begin
          busy <= 1'b0;
          if (in_data == 8'hAA) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else begin
            state    <= S_ERROR;
            error    <= 1'b1;
            err_code <= 2'd3;
          end
        end
        default: begin
          // DONE / ERROR hold their flags until the next frame reaches LEN_LO
          if (in_data == 8'hAA) state <= S_SYNC;
        end
      endcase
    end
  end

endmodule
